// File: rtl/tx_noise_pkg.sv
// Shared types and default constants for the tx + AWGN run controller.
package tx_noise_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int OVERSAMP_DEF  = 4;
    localparam int NBAUD_DEF     = 6;
    localparam int NBT_SIGMA_DEF = 8;
    localparam int NBF_SIGMA_DEF = 7;
    localparam logic signed [NBT_SIGMA_DEF-1:0] SIGMA_RST_DEF = 8'sh1c;

    // Cycles needed to push the first real symbol through the TX filter span.
    function automatic int flush_len(input int nbaud, input int oversamp);
        return nbaud * oversamp;
    endfunction

    localparam int FLUSH_LEN = flush_len(NBAUD_DEF, OVERSAMP_DEF);

endpackage

// File: rtl/tx_phase_cnt.sv
// Modulo-OVERSAMP oversampling phase counter with a per-symbol baud strobe.
module tx_phase_cnt #(
    parameter int OVERSAMP = 4,
    parameter int NB_PHASE = 2
) (
    input  logic                clk,
    input  logic                i_reset,
    input  logic                en,
    input  logic                clr,
    output logic [NB_PHASE-1:0] phase,
    output logic                baud
);

    always_ff @(posedge clk) begin
        if (i_reset || clr) begin
            phase <= '0;
        end else if (en) begin
            if (phase == NB_PHASE'(OVERSAMP - 1))
                phase <= '0;
            else
                phase <= phase + NB_PHASE'(1);
        end
    end

    assign baud = en && (phase == '0);

endmodule

// File: rtl/tx_noise_seq_ctrl.sv
// Run controller for the PRBS9 -> TX filter -> AWGN datapath.
// Optional pause input enabled by defining TX_NOISE_CTRL_PAUSE_EN.
module tx_noise_seq_ctrl
    import tx_noise_pkg::*;
#(
    parameter int OVERSAMP  = OVERSAMP_DEF,
    parameter int NB_PHASE  = 2,
    parameter int NBAUD     = NBAUD_DEF,
    parameter int N_LOGS    = 4000000,
    parameter int NB_CNT    = 22,
    parameter int NBT_SIGMA = NBT_SIGMA_DEF,
    parameter logic signed [NBT_SIGMA-1:0] SIGMA_RST = SIGMA_RST_DEF
) (
    input  logic                        clk,
    input  logic                        i_reset,
    input  logic                        i_start,
    input  logic                        i_abort,
`ifdef TX_NOISE_CTRL_PAUSE_EN
    input  logic                        i_pause,
`endif
    input  logic                        i_cfg_valid,
    input  logic signed [NBT_SIGMA-1:0] i_cfg_sigma,
    output logic                        o_cfg_ready,
    output logic signed [NBT_SIGMA-1:0] o_sigma,
    output logic                        o_prbs_en,
    output logic                        o_noise_en,
    output logic                        o_baud_en,
    output logic [NB_PHASE-1:0]         o_phase,
    output logic                        o_log_valid,
    output logic                        o_bit_log_valid,
    output logic [NB_CNT-1:0]           o_sample_cnt,
    output logic                        o_busy,
    output logic                        o_done
);

    localparam int FLUSH_N = flush_len(NBAUD, OVERSAMP);
    localparam int NB_FL   = (FLUSH_N > 1) ? $clog2(FLUSH_N) : 1;

    state_t             state, state_nx;
    logic [NB_FL-1:0]   flush_cnt;
    logic               pause_q;
    logic               active, start_go, clr, flush_last, run_last;

    // Pause is registered so the enables never depend combinationally on an input.
`ifdef TX_NOISE_CTRL_PAUSE_EN
    always_ff @(posedge clk) begin
        if (i_reset || i_abort)
            pause_q <= 1'b0;
        else
            pause_q <= i_pause;
    end
`else
    assign pause_q = 1'b0;
`endif

    assign o_busy          = (state == FLUSH) || (state == RUN);
    assign o_done          = (state == DONE);
    assign o_cfg_ready     = (state == IDLE) || (state == DONE);
    assign active          = o_busy && !pause_q;
    assign o_prbs_en       = active;
    assign o_noise_en      = active;
    assign o_log_valid     = (state == RUN) && !pause_q;
    assign o_bit_log_valid = o_log_valid && (o_phase == '0);

    assign start_go   = o_cfg_ready && i_start && !i_abort;
    assign clr        = i_abort || start_go;
    assign flush_last = (flush_cnt == NB_FL'(FLUSH_N - 1));
    assign run_last   = (o_sample_cnt == NB_CNT'(N_LOGS - 1));

    tx_phase_cnt #(
        .OVERSAMP (OVERSAMP),
        .NB_PHASE (NB_PHASE)
    ) u_phase (
        .clk     (clk),
        .i_reset (i_reset),
        .en      (active),
        .clr     (clr),
        .phase   (o_phase),
        .baud    (o_baud_en)
    );

    always_comb begin
        state_nx = state;
        if (i_abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (i_start) state_nx = FLUSH;
                FLUSH:      if (!pause_q && flush_last) state_nx = RUN;
                RUN:        if (!pause_q && run_last) state_nx = DONE;
                default:    state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state        <= IDLE;
            flush_cnt    <= '0;
            o_sample_cnt <= '0;
            o_sigma      <= SIGMA_RST;
        end else begin
            state <= state_nx;
            if (i_cfg_valid && o_cfg_ready)
                o_sigma <= i_cfg_sigma;
            // Sample count saturates at N_LOGS in DONE because RUN is left on the last sample.
            if (clr) begin
                flush_cnt    <= '0;
                o_sample_cnt <= '0;
            end else if (state == FLUSH && !pause_q) begin
                flush_cnt <= flush_cnt + NB_FL'(1);
            end else if (o_log_valid) begin
                o_sample_cnt <= o_sample_cnt + NB_CNT'(1);
            end
        end
    end

endmodule

// File: doc/tx_noise_seq_ctrl.md
Name: tx_noise_seq_ctrl

Overview:
- Run controller that sequences the tx + AWGN datapath: PRBS9 I/Q sources → TX shaping filter → noise adder.
- Generates the baud strobe and oversampling phase for the PRBS generators and filter.
- Gates the noise generators, holds the sigma configuration, and flushes filter latency before data is declared valid.
- Produces the sample/bit log qualifiers and run-completion status that replace the free-running fixed-count capture loop.

Parameters:
- OVERSAMP, 4, samples per symbol; power of 2.
- NB_PHASE, 2, phase counter width, = log2(OVERSAMP).
- NBAUD, 6, TX filter span in symbols; flush length = NBAUD*OVERSAMP cycles.
- N_LOGS, 4000000, oversampled samples logged per run.
- NB_CNT, 22, sample counter width, >= ceil(log2(N_LOGS)).
- NBT_SIGMA, 8, sigma width, signed, fractional bits NBF_SIGMA=7.
- SIGMA_RST, 8'sh1c, sigma value after reset.

Ports:
- clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  level; begins a run when sampled high in IDLE or DONE.
- i_abort  in  1  returns to IDLE from any state; has priority over i_start.
- i_cfg_valid  in  1  sigma write request.
- i_cfg_sigma  in  NBT_SIGMA  sigma value to load.
- o_cfg_ready  out  1  high in IDLE and DONE only.
- o_sigma  out  NBT_SIGMA  registered sigma to the noise scaler.
- o_prbs_en  out  1  enables PRBS generators, filter and phase counter.
- o_noise_en  out  1  enables the Gaussian noise generators.
- o_baud_en  out  1  one-cycle strobe per symbol (phase==0 and o_prbs_en).
- o_phase  out  NB_PHASE  oversampling phase, 0..OVERSAMP-1.
- o_log_valid  out  1  noisy I/Q sample is valid to log this cycle.
- o_bit_log_valid  out  1  PRBS bit is valid to log (o_log_valid and phase==0).
- o_sample_cnt  out  NB_CNT  count of samples logged in the current run.
- o_busy  out  1  state is FLUSH or RUN.
- o_done  out  1  state is DONE.

Behaviour:
- Reset values: state=IDLE, o_sigma=SIGMA_RST, o_phase=0, o_sample_cnt=0, flush counter=0. All enables, valids, o_busy and o_done are 0; o_cfg_ready=1.
- All outputs are registered or decoded directly from registered state; there are no combinational input-to-output paths.

State machine:
- IDLE: all enables low. i_start → FLUSH. On that transition, o_phase and o_sample_cnt are cleared and the flush counter is cleared.
- FLUSH: o_prbs_en=o_noise_en=1; phase increments modulo OVERSAMP. After NBAUD*OVERSAMP cycles (24 at default) → RUN. This is always phase-aligned: the first RUN cycle has phase 0.
- RUN: enables stay high and o_log_valid=1 every cycle; o_sample_cnt increments per logged sample. When the cycle logging sample N_LOGS-1 completes → DONE.
- DONE: enables and valids low; o_done held high; o_sample_cnt held at N_LOGS. i_start → FLUSH, which clears the counters.
- i_abort in any state → IDLE next cycle; counters are cleared and o_sigma is retained.

Latency:
- i_start sampled at cycle t → o_prbs_en high at t+1.
- First o_log_valid at t+1+NBAUD*OVERSAMP.
- o_done rises the cycle after the last o_log_valid.
- Exactly N_LOGS log pulses per run; exactly N_LOGS/OVERSAMP bit-log pulses.

Config handshake:
- A write is accepted on i_cfg_valid && o_cfg_ready; o_sigma updates the next cycle.
- Requests in FLUSH/RUN stall; o_sigma is unchanged during a run.
- Config and start in the same cycle: both are accepted, and the new sigma is visible from the first FLUSH cycle.
- i_start held high: DONE auto-restarts on the next cycle.

Optional Feature:
- Macro TX_NOISE_CTRL_PAUSE_EN.
- Defined: adds input i_pause (1 bit). While high in FLUSH or RUN, all enables, o_baud_en and o_log_valid are low, and the phase, flush and sample counters freeze. Operation resumes exactly where it stopped. i_abort still wins over i_pause.
- Undefined: port absent; behaviour as above.

Decomposition:
- Package tx_noise_pkg holds:
  - state enum (IDLE=0, FLUSH=1, RUN=2, DONE=3);
  - default OVERSAMP, NBAUD and sigma constants;
  - the FLUSH_LEN constant.
- One sub-module, tx_phase_cnt: modulo-OVERSAMP counter with enable/clear, outputting phase and the baud strobe.

Test Plan:
- Bench overrides N_LOGS=16. Reset, then i_start pulse at t → o_prbs_en=1 at t+1; first o_log_valid at t+25 with o_phase=0; exactly 16 o_log_valid and 4 o_bit_log_valid; o_done=1 at t+41 and o_sample_cnt=16.
- In IDLE, i_cfg_valid with sigma 8'sh20 → o_sigma=8'sh20 next cycle. The same request during RUN → o_cfg_ready=0 and o_sigma stays 8'sh1c until DONE, then updates.
- i_abort asserted mid-RUN (sample 7) together with i_start → IDLE next cycle; o_sample_cnt=0; all enables 0.
- i_start held high → DONE lasts 1 cycle, then FLUSH; o_sample_cnt resets to 0; second run also produces 16 logs.
- o_baud_en period is exactly 4 cycles through FLUSH and RUN and is never asserted in IDLE or DONE.
- With TX_NOISE_CTRL_PAUSE_EN, i_pause high for 5 cycles mid-RUN → o_log_valid total is still 16; o_done is delayed by exactly 5 cycles; phase resumes unchanged.
